// File: rtl/filter_pkg.sv
// -----------------------------------------------------------------------------
// filter_pkg
// Types and helpers shared by the filter mode controller and the filter
// datapath.
//   filter_mode_e : 2-bit mode driven to the datapath (OFF/IDLE/IIR/FIR)
//   ctrl_state_e  : controller state encoding
//   decode_mode() : 3-bit request word -> filter_mode_e
//   settled_mode(): settled controller state -> filter_mode_e
// -----------------------------------------------------------------------------
package filter_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'd0,
    MODE_IDLE = 2'd1,
    MODE_IIR  = 2'd2,
    MODE_FIR  = 2'd3
  } filter_mode_e;

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_IDLE  = 3'd1,
    S_IIR   = 3'd2,
    S_FIR   = 3'd3,
    S_FLUSH = 3'd4
  } ctrl_state_e;

  // Request word: bit0 enable, bit1 filter on, bit2 1=IIR / 0=FIR.
  function automatic filter_mode_e decode_mode(input logic [MODE_W-1:0] req);
    filter_mode_e m;
    if (!req[0])      m = MODE_OFF;
    else if (!req[1]) m = MODE_IDLE;
    else if (req[2])  m = MODE_IIR;
    else              m = MODE_FIR;
    return m;
  endfunction

  // FLUSH has no settled mode of its own; it reports OFF here and the
  // controller substitutes the flush target.
  function automatic filter_mode_e settled_mode(input ctrl_state_e s);
    filter_mode_e m;
    case (s)
      S_IDLE:  m = MODE_IDLE;
      S_IIR:   m = MODE_IIR;
      S_FIR:   m = MODE_FIR;
      default: m = MODE_OFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/filter_mode_ctrl_if.sv
// -----------------------------------------------------------------------------
// filter_mode_ctrl_if
// Bundles the mode-request handshake, the sample strobe and the datapath
// control outputs of the filter mode controller.
//   master : request source / datapath side (drives request and strobe)
//   slave  : controller side (drives ready and the datapath controls)
// Signals:
//   mode_valid_i   request present
//   mode_i         3-bit request word
//   mode_ready_o   request accepted when high together with mode_valid_i
//   sample_valid_i one-cycle strobe per audio sample
//   mode_o         filter mode to datapath
//   filt_clear_o   one-cycle clear of filter delay lines
//   mute_o         datapath output forced to zero while high
//   busy_o         high while the new filter settles
// -----------------------------------------------------------------------------
interface filter_mode_ctrl_if;
  import filter_pkg::*;

  logic              mode_valid_i;
  logic [MODE_W-1:0] mode_i;
  logic              mode_ready_o;
  logic              sample_valid_i;
  filter_mode_e      mode_o;
  logic              filt_clear_o;
  logic              mute_o;
  logic              busy_o;

  modport master (
    output mode_valid_i, mode_i, sample_valid_i,
    input  mode_ready_o, mode_o, filt_clear_o, mute_o, busy_o
  );

  modport slave (
    input  mode_valid_i, mode_i, sample_valid_i,
    output mode_ready_o, mode_o, filt_clear_o, mute_o, busy_o
  );

endinterface

// File: rtl/filter_mode_ctrl_flush_counter.sv
// -----------------------------------------------------------------------------
// flush_counter
// Down-counter timing the mute window after a filter change.
//   clk_i, rst_i  clock, synchronous active-high reset
//   load_i        load load_val_i (start of a flush)
//   load_val_i    number of sample strobes to wait
//   clear_i       zero the counter (flush aborted)
//   dec_i         decrement on a counted sample strobe
//   tc_o          terminal count: the next counted strobe ends the flush
// -----------------------------------------------------------------------------
module flush_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             clear_i,
  input  logic             dec_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q;

  // Clear wins over load so an abort can never leave a stale count behind.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign tc_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/filter_mode_ctrl.sv
// -----------------------------------------------------------------------------
// filter_mode_ctrl
// Sequences the audio filter path between OFF, IDLE (bypass), IIR and FIR.
// Every entry into a filtering mode clears the filter state and mutes the
// output for FLUSH_SAMPLES sample strobes while the new filter settles.
//   clk_i  system clock, rising edge
//   rst_i  synchronous active-high reset
//   bus    filter_mode_ctrl_if.slave (request handshake, sample strobe,
//          datapath mode/clear/mute/busy)
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_OFF   | filter path off
// S_IDLE  | bypass, data passes unfiltered
// S_IIR   | IIR filter settled and audible
// S_FIR   | FIR filter settled and audible
// S_FLUSH | target filter running warm, output muted, counting strobes
// -----------------------------------------------------------------------------
module filter_mode_ctrl
  import filter_pkg::*;
#(
  parameter  int FLUSH_SAMPLES = 8,
  localparam int CNT_W         = $clog2(FLUSH_SAMPLES + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  filter_mode_ctrl_if.slave   bus
);

  ctrl_state_e  state_q, state_d;
  filter_mode_e target_q, target_d;
  filter_mode_e req_mode;
  filter_mode_e cur_mode;
  filter_mode_e mode_d;
  logic         ready;
  logic         accept;
  logic         cnt_load;
  logic         cnt_clear;
  logic         cnt_dec;
  logic         cnt_tc;
  logic         in_flush_d;

  flush_counter #(
    .CNT_W (CNT_W)
  ) u_flush_counter (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (cnt_load),
    .load_val_i (CNT_W'(FLUSH_SAMPLES)),
    .clear_i    (cnt_clear),
    .dec_i      (cnt_dec),
    .tc_o       (cnt_tc)
  );

  always_comb begin
    req_mode  = decode_mode(bus.mode_i);
    cur_mode  = settled_mode(state_q);
    // OFF is always accepted so a flush can be aborted at any time.
    ready     = (state_q != S_FLUSH) || (req_mode == MODE_OFF);
    accept    = bus.mode_valid_i && ready;

    state_d   = state_q;
    target_d  = target_q;
    cnt_load  = 1'b0;
    cnt_clear = 1'b0;
    cnt_dec   = 1'b0;

    case (state_q)
      S_OFF, S_IDLE, S_IIR, S_FIR: begin
        if (accept && (req_mode != cur_mode)) begin
          case (req_mode)
            MODE_OFF: begin
              state_d  = S_OFF;
              target_d = MODE_OFF;
            end
            MODE_IDLE: begin
              state_d  = S_IDLE;
              target_d = MODE_IDLE;
            end
            default: begin
              // Covers IIR<->FIR as well: the other filter starts cold.
              state_d  = S_FLUSH;
              target_d = req_mode;
              cnt_load = 1'b1;
            end
          endcase
        end
      end
      S_FLUSH: begin
        if (accept) begin
          state_d   = S_OFF;
          target_d  = MODE_OFF;
          cnt_clear = 1'b1;
        end else if (bus.sample_valid_i) begin
          cnt_dec = 1'b1;
          if (cnt_tc) begin
            state_d = (target_q == MODE_IIR) ? S_IIR : S_FIR;
          end
        end
      end
      default: begin
        state_d   = S_OFF;
        target_d  = MODE_OFF;
        cnt_clear = 1'b1;
      end
    endcase

    in_flush_d = (state_d == S_FLUSH);
    mode_d     = in_flush_d ? target_d : settled_mode(state_d);
  end

  assign bus.mode_ready_o = ready;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q          <= S_OFF;
      target_q         <= MODE_OFF;
      bus.mode_o       <= MODE_OFF;
      bus.filt_clear_o <= 1'b0;
      bus.mute_o       <= 1'b0;
      bus.busy_o       <= 1'b0;
    end else begin
      state_q          <= state_d;
      target_q         <= target_d;
      bus.mode_o       <= mode_d;
      // The clear pulse coincides with the first FLUSH cycle only.
      bus.filt_clear_o <= cnt_load;
      bus.mute_o       <= in_flush_d;
      bus.busy_o       <= in_flush_d;
    end
  end

endmodule

// File: tb/tb_filter_mode_ctrl.sv
module tb_filter_mode_ctrl;
  import filter_pkg::*;

  localparam int FLUSH = 8;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  filter_mode_ctrl_if bus ();

  filter_mode_ctrl #(
    .FLUSH_SAMPLES (FLUSH)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       rst;
    logic       valid;
    logic [2:0] mode;
    logic       strobe;
    logic [4:0] exp;      // {mode_o, filt_clear_o, mute_o, busy_o}
    logic       chk_rdy;
    logic       rdy;
  } stim_t;

  stim_t      tbl[$];
  logic [4:0] sb[$];
  logic [4:0] got, exp_v;
  int         checks = 0;
  int         errors = 0;

  function automatic logic [4:0] obs();
    return {bus.mode_o, bus.filt_clear_o, bus.mute_o, bus.busy_o};
  endfunction

  task automatic add(input logic rst, input logic valid, input logic [2:0] mode,
                     input logic strobe, input filter_mode_e m, input logic clr,
                     input logic mute, input logic chk_rdy, input logic rdy);
    stim_t s;
    s.rst = rst; s.valid = valid; s.mode = mode; s.strobe = strobe;
    s.exp = {m, clr, mute, mute};
    s.chk_rdy = chk_rdy; s.rdy = rdy;
    tbl.push_back(s);
  endtask

  // Cycles following an accept into FLUSH; strobe when c % period == phase,
  // c=0 being the clear-pulse cycle. Stops after the n-th strobe.
  task automatic add_flush(input filter_mode_e m, input int period, input int phase,
                           input int n, input logic hv, input logic [2:0] hm);
    int s = 0;
    bit st;
    for (int c = 0; s < n; c++) begin
      st = ((c % period) == phase);
      if (st) s++;
      add(1'b0, hv, hm, st, m, 1'b0, (s < FLUSH), hv, 1'b0);
    end
  endtask

  task automatic apply(input stim_t s);
    rst_i              = s.rst;
    bus.mode_valid_i   = s.valid;
    bus.mode_i         = s.mode;
    bus.sample_valid_i = s.strobe;
    sb.push_back(s.exp);
    #1;
  endtask

  task automatic test_reset();
    add(1'b1, 1'b0, 3'b000, 1'b0, MODE_OFF, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 3'b000, 1'b0, MODE_OFF, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 3'b111, 1'b0, MODE_OFF, 1'b0, 1'b0, 1'b1, 1'b1);
    foreach (tbl[i]) begin
      apply(tbl[i]);
      if (tbl[i].chk_rdy) begin
        checks++;
        if (bus.mode_ready_o !== tbl[i].rdy) begin
          errors++; $display("FAIL reset.ready step %0d got %b exp %b", i, bus.mode_ready_o, tbl[i].rdy);
        end
      end
      @(posedge clk_i); #1;
      got = obs(); exp_v = sb.pop_front(); checks++;
      if (got !== exp_v) begin
        errors++; $display("FAIL reset.out step %0d got {mode,clr,mute,busy}=%b exp %b", i, got, exp_v);
      end
    end
    tbl.delete();
  endtask

  task automatic test_off_to_iir();
    add(1'b0, 1'b1, 3'b111, 1'b0, MODE_IIR, 1'b1, 1'b1, 1'b1, 1'b1);
    add_flush(MODE_IIR, 4, 3, FLUSH, 1'b0, 3'b000);
    add(1'b0, 1'b0, 3'b000, 1'b0, MODE_IIR, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 3'b000, 1'b1, MODE_IIR, 1'b0, 1'b0, 1'b0, 1'b0);
    foreach (tbl[i]) begin
      apply(tbl[i]);
      if (tbl[i].chk_rdy) begin
        checks++;
        if (bus.mode_ready_o !== tbl[i].rdy) begin
          errors++; $display("FAIL off_to_iir.ready step %0d got %b exp %b", i, bus.mode_ready_o, tbl[i].rdy);
        end
      end
      @(posedge clk_i); #1;
      got = obs(); exp_v = sb.pop_front(); checks++;
      if (got !== exp_v) begin
        errors++; $display("FAIL off_to_iir.out step %0d got {mode,clr,mute,busy}=%b exp %b", i, got, exp_v);
      end
    end
    tbl.delete();
  endtask

  task automatic test_same_mode();
    add(1'b0, 1'b1, 3'b111, 1'b1, MODE_IIR, 1'b0, 1'b0, 1'b1, 1'b1);
    add(1'b0, 1'b1, 3'b111, 1'b0, MODE_IIR, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 3'b000, 1'b1, MODE_IIR, 1'b0, 1'b0, 1'b0, 1'b0);
    foreach (tbl[i]) begin
      apply(tbl[i]);
      if (tbl[i].chk_rdy) begin
        checks++;
        if (bus.mode_ready_o !== tbl[i].rdy) begin
          errors++; $display("FAIL same_mode.ready step %0d got %b exp %b", i, bus.mode_ready_o, tbl[i].rdy);
        end
      end
      @(posedge clk_i); #1;
      got = obs(); exp_v = sb.pop_front(); checks++;
      if (got !== exp_v) begin
        errors++; $display("FAIL same_mode.out step %0d got {mode,clr,mute,busy}=%b exp %b", i, got, exp_v);
      end
    end
    tbl.delete();
  endtask

  task automatic test_idle_from_fir();
    add(1'b0, 1'b1, 3'b011, 1'b0, MODE_FIR, 1'b1, 1'b1, 1'b0, 1'b0);
    add_flush(MODE_FIR, 2, 1, FLUSH, 1'b0, 3'b000);
    add(1'b0, 1'b1, 3'b001, 1'b0, MODE_IDLE, 1'b0, 1'b0, 1'b1, 1'b1);
    add(1'b0, 1'b0, 3'b000, 1'b1, MODE_IDLE, 1'b0, 1'b0, 1'b0, 1'b0);
    foreach (tbl[i]) begin
      apply(tbl[i]);
      if (tbl[i].chk_rdy) begin
        checks++;
        if (bus.mode_ready_o !== tbl[i].rdy) begin
          errors++; $display("FAIL idle_from_fir.ready step %0d got %b exp %b", i, bus.mode_ready_o, tbl[i].rdy);
        end
      end
      @(posedge clk_i); #1;
      got = obs(); exp_v = sb.pop_front(); checks++;
      if (got !== exp_v) begin
        errors++; $display("FAIL idle_from_fir.out step %0d got {mode,clr,mute,busy}=%b exp %b", i, got, exp_v);
      end
    end
    tbl.delete();
  endtask

  task automatic test_flush_abort();
    add(1'b0, 1'b1, 3'b111, 1'b0, MODE_IIR, 1'b1, 1'b1, 1'b0, 1'b0);
    add_flush(MODE_IIR, 2, 1, 3, 1'b0, 3'b000);
    add(1'b0, 1'b1, 3'b000, 1'b1, MODE_OFF, 1'b0, 1'b0, 1'b1, 1'b1);
    add(1'b0, 1'b0, 3'b000, 1'b1, MODE_OFF, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 3'b000, 1'b1, MODE_OFF, 1'b0, 1'b0, 1'b0, 1'b0);
    foreach (tbl[i]) begin
      apply(tbl[i]);
      if (tbl[i].chk_rdy) begin
        checks++;
        if (bus.mode_ready_o !== tbl[i].rdy) begin
          errors++; $display("FAIL flush_abort.ready step %0d got %b exp %b", i, bus.mode_ready_o, tbl[i].rdy);
        end
      end
      @(posedge clk_i); #1;
      got = obs(); exp_v = sb.pop_front(); checks++;
      if (got !== exp_v) begin
        errors++; $display("FAIL flush_abort.out step %0d got {mode,clr,mute,busy}=%b exp %b", i, got, exp_v);
      end
    end
    tbl.delete();
  endtask

  task automatic test_held_request();
    add(1'b0, 1'b1, 3'b011, 1'b0, MODE_FIR, 1'b1, 1'b1, 1'b1, 1'b1);
    add_flush(MODE_FIR, 3, 2, FLUSH, 1'b1, 3'b111);
    add(1'b0, 1'b1, 3'b111, 1'b0, MODE_IIR, 1'b1, 1'b1, 1'b1, 1'b1);
    add_flush(MODE_IIR, 3, 0, FLUSH, 1'b0, 3'b000);
    add(1'b0, 1'b0, 3'b000, 1'b0, MODE_IIR, 1'b0, 1'b0, 1'b0, 1'b0);
    foreach (tbl[i]) begin
      apply(tbl[i]);
      if (tbl[i].chk_rdy) begin
        checks++;
        if (bus.mode_ready_o !== tbl[i].rdy) begin
          errors++; $display("FAIL held_request.ready step %0d got %b exp %b", i, bus.mode_ready_o, tbl[i].rdy);
        end
      end
      @(posedge clk_i); #1;
      got = obs(); exp_v = sb.pop_front(); checks++;
      if (got !== exp_v) begin
        errors++; $display("FAIL held_request.out step %0d got {mode,clr,mute,busy}=%b exp %b", i, got, exp_v);
      end
    end
    tbl.delete();
  endtask

  task automatic test_coincident_strobe();
    add(1'b0, 1'b1, 3'b000, 1'b0, MODE_OFF, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 3'b011, 1'b1, MODE_FIR, 1'b1, 1'b1, 1'b1, 1'b1);
    add_flush(MODE_FIR, 2, 0, FLUSH, 1'b0, 3'b000);
    add(1'b0, 1'b0, 3'b000, 1'b1, MODE_FIR, 1'b0, 1'b0, 1'b0, 1'b0);
    foreach (tbl[i]) begin
      apply(tbl[i]);
      if (tbl[i].chk_rdy) begin
        checks++;
        if (bus.mode_ready_o !== tbl[i].rdy) begin
          errors++; $display("FAIL coincident.ready step %0d got %b exp %b", i, bus.mode_ready_o, tbl[i].rdy);
        end
      end
      @(posedge clk_i); #1;
      got = obs(); exp_v = sb.pop_front(); checks++;
      if (got !== exp_v) begin
        errors++; $display("FAIL coincident.out step %0d got {mode,clr,mute,busy}=%b exp %b", i, got, exp_v);
      end
    end
    tbl.delete();
  endtask

  task automatic test_reset_mid_flush();
    add(1'b0, 1'b1, 3'b111, 1'b0, MODE_IIR, 1'b1, 1'b1, 1'b0, 1'b0);
    add_flush(MODE_IIR, 2, 1, 2, 1'b0, 3'b000);
    add(1'b1, 1'b0, 3'b000, 1'b1, MODE_OFF, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 3'b111, 1'b1, MODE_OFF, 1'b0, 1'b0, 1'b1, 1'b1);
    add(1'b0, 1'b0, 3'b000, 1'b1, MODE_OFF, 1'b0, 1'b0, 1'b0, 1'b0);
    foreach (tbl[i]) begin
      apply(tbl[i]);
      if (tbl[i].chk_rdy) begin
        checks++;
        if (bus.mode_ready_o !== tbl[i].rdy) begin
          errors++; $display("FAIL reset_mid_flush.ready step %0d got %b exp %b", i, bus.mode_ready_o, tbl[i].rdy);
        end
      end
      @(posedge clk_i); #1;
      got = obs(); exp_v = sb.pop_front(); checks++;
      if (got !== exp_v) begin
        errors++; $display("FAIL reset_mid_flush.out step %0d got {mode,clr,mute,busy}=%b exp %b", i, got, exp_v);
      end
    end
    tbl.delete();
  endtask

  initial begin
    bus.mode_valid_i   = 1'b0;
    bus.mode_i         = 3'b000;
    bus.sample_valid_i = 1'b0;
    test_reset();
    test_off_to_iir();
    test_same_mode();
    test_idle_from_fir();
    test_flush_abort();
    test_held_request();
    test_coincident_strobe();
    test_reset_mid_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete got running exp finished");
    $fatal(1);
  end

endmodule
